// File: rtl/ifstage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ifstage_pkg
// Brief    : Redirect-mode encodings and default widths for the fetch stage.
// Revision : 1.0 - initial release
// ============================================================================
package ifstage_pkg;

    localparam int c_DEFAULT_XLEN = 32;

    typedef enum logic [1:0] {
        REDIR_NONE = 2'b00,
        REDIR_REL  = 2'b01,
        REDIR_ABS  = 2'b10,
        REDIR_RSVD = 2'b11
    } redir_mode_e;

endpackage
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue
// Brief    : Circular FIFO with wrap-bit pointers, synchronous clear and count.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_queue #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_clear,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_empty
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_PW = c_AW + 1;

    logic [c_PW-1:0]  r_wr_ptr_q;
    logic [c_PW-1:0]  w_wr_ptr_d;
    logic [c_PW-1:0]  r_rd_ptr_q;
    logic [c_PW-1:0]  w_rd_ptr_d;
    logic [WIDTH-1:0] r_mem_q [DEPTH];
    logic [WIDTH-1:0] w_mem_d [DEPTH];
    logic             w_full;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_count = r_wr_ptr_q - r_rd_ptr_q;
    assign o_empty = (r_wr_ptr_q == r_rd_ptr_q);
    assign w_full  = (r_wr_ptr_q[c_AW-1:0] == r_rd_ptr_q[c_AW-1:0]) &&
                     (r_wr_ptr_q[c_AW]     != r_rd_ptr_q[c_AW]);
    assign o_rdata = r_mem_q[r_rd_ptr_q[c_AW-1:0]];

    always_comb begin
        w_do_push  = i_push && (!w_full || i_pop);
        w_do_pop   = i_pop && !o_empty;
        w_wr_ptr_d = r_wr_ptr_q;
        w_rd_ptr_d = r_rd_ptr_q;
        w_mem_d    = r_mem_q;
        if (i_clear) begin
            w_wr_ptr_d = '0;
            w_rd_ptr_d = '0;
        end else begin
            if (w_do_push) begin
                w_mem_d[r_wr_ptr_q[c_AW-1:0]] = i_wdata;
                w_wr_ptr_d = r_wr_ptr_q + c_PW'(1);
            end
            if (w_do_pop) begin
                w_rd_ptr_d = r_rd_ptr_q + c_PW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr_q <= '0;
            r_rd_ptr_q <= '0;
        end else begin
            r_wr_ptr_q <= w_wr_ptr_d;
            r_rd_ptr_q <= w_rd_ptr_d;
        end
    end

    // Storage needs no reset: entries are only observed between push and pop.
    always_ff @(posedge clk) begin
        r_mem_q <= w_mem_d;
    end

    a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
        !(i_push && w_full && !i_pop));

endmodule
`default_nettype wire

// File: rtl/ifstage_pipe.sv
`default_nettype none
// ============================================================================
// Module   : ifstage_pipe
// Brief    : Instruction fetch stage with credit-based issue, fetch queue and
//            relative/absolute redirects that flush queued and in-flight work.
// Revision : 1.0 - initial release
// ============================================================================
module ifstage_pipe
    import ifstage_pkg::*;
#(
    parameter int              XLEN       = c_DEFAULT_XLEN,
    parameter int              IADDR_BITS = 10,
    parameter int              FQ_DEPTH   = 4,
    parameter logic [XLEN-1:0] RESET_PC   = '0
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  Redir_Valid,
    input  logic [1:0]            Redir_Mode,
    input  logic [XLEN-1:0]       Redir_Base,
    input  logic [XLEN-1:0]       Redir_Immed,
    output logic                  Imem_Req,
    output logic [IADDR_BITS-1:0] Imem_Addr,
    input  logic [XLEN-1:0]       Imem_Rdata,
    output logic                  Instr_Valid,
    input  logic                  Instr_Ready,
    output logic [XLEN-1:0]       Instr,
    output logic [XLEN-1:0]       Instr_PC
);

    localparam int c_CW = $clog2(FQ_DEPTH) + 1;

    logic [XLEN-1:0]   r_pc_q;
    logic [XLEN-1:0]   w_pc_d;
    logic              r_inflight_q;
    logic              w_inflight_d;
    logic [XLEN-1:0]   r_inflight_pc_q;
    logic [XLEN-1:0]   w_inflight_pc_d;

    logic              w_redir;
    logic [XLEN-1:0]   w_target_raw;
    logic [XLEN-1:0]   w_target;
    logic [c_CW-1:0]   w_credit;
    logic              w_issue;
    logic              w_push;
    logic              w_pop;

    logic [2*XLEN-1:0] w_head;
    logic [c_CW-1:0]   w_q_count;
    logic              w_q_empty;

    always_comb begin
        w_redir      = Redir_Valid &&
                       ((Redir_Mode == REDIR_REL) || (Redir_Mode == REDIR_ABS));
        w_target_raw = (Redir_Mode == REDIR_REL) ?
                       (Redir_Base + XLEN'(32'd4) + Redir_Immed) : Redir_Immed;
        w_target     = {w_target_raw[XLEN-1:2], 2'b00};
        w_credit     = w_q_count + c_CW'(r_inflight_q);
        // Reset_n gates the strobe so no request is visible while held in reset.
        w_issue      = Reset_n && !w_redir && (w_credit < c_CW'(FQ_DEPTH));
        w_push       = r_inflight_q && !w_redir;
        w_pop        = !w_q_empty && Instr_Ready;

        w_pc_d          = r_pc_q;
        w_inflight_d    = w_issue;
        w_inflight_pc_d = r_inflight_pc_q;
        if (w_redir) begin
            w_pc_d = w_target;
        end else if (w_issue) begin
            w_pc_d          = r_pc_q + XLEN'(32'd4);
            w_inflight_pc_d = r_pc_q;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_pc_q          <= RESET_PC;
            r_inflight_q    <= 1'b0;
            r_inflight_pc_q <= '0;
        end else begin
            r_pc_q          <= w_pc_d;
            r_inflight_q    <= w_inflight_d;
            r_inflight_pc_q <= w_inflight_pc_d;
        end
    end

    fetch_queue #(
        .WIDTH (2 * XLEN),
        .DEPTH (FQ_DEPTH)
    ) u_fetch_queue (
        .clk     (Clk),
        .rst_n   (Reset_n),
        .i_clear (w_redir),
        .i_push  (w_push),
        .i_wdata ({r_inflight_pc_q, Imem_Rdata}),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_count (w_q_count),
        .o_empty (w_q_empty)
    );

    assign Imem_Req    = w_issue;
    assign Imem_Addr   = r_pc_q[IADDR_BITS+1:2];
    assign Instr_Valid = !w_q_empty;
    assign Instr       = w_q_empty ? '0 : w_head[XLEN-1:0];
    assign Instr_PC    = w_q_empty ? '0 : w_head[2*XLEN-1:XLEN];

endmodule
`default_nettype wire

// File: tb/tb_ifstage_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_ifstage_pipe
// Brief    : Self-checking bench for ifstage_pipe with an expected-stream queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ifstage_pipe;
    import ifstage_pkg::*;

    logic        Clk         = 1'b0;
    logic        Reset_n     = 1'b0;
    logic        Redir_Valid = 1'b0;
    logic [1:0]  Redir_Mode  = 2'b00;
    logic [31:0] Redir_Base  = '0;
    logic [31:0] Redir_Immed = '0;
    logic        Imem_Req;
    logic [9:0]  Imem_Addr;
    logic [31:0] Imem_Rdata  = '0;
    logic        Instr_Valid;
    logic        Instr_Ready = 1'b0;
    logic [31:0] Instr;
    logic [31:0] Instr_PC;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    exp_t sb[$];
    int   n_vec   = 0;
    int   n_err   = 0;
    int   req_cnt = 0;

    ifstage_pipe #(
        .XLEN       (32),
        .IADDR_BITS (10),
        .FQ_DEPTH   (4),
        .RESET_PC   (32'h0)
    ) dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .Redir_Valid (Redir_Valid),
        .Redir_Mode  (Redir_Mode),
        .Redir_Base  (Redir_Base),
        .Redir_Immed (Redir_Immed),
        .Imem_Req    (Imem_Req),
        .Imem_Addr   (Imem_Addr),
        .Imem_Rdata  (Imem_Rdata),
        .Instr_Valid (Instr_Valid),
        .Instr_Ready (Instr_Ready),
        .Instr       (Instr),
        .Instr_PC    (Instr_PC)
    );

    always #5 Clk = ~Clk;

    function automatic logic [31:0] mem_word(input logic [9:0] a);
        return {22'd0, a};
    endfunction

    always @(posedge Clk) begin
        if (Imem_Req) Imem_Rdata <= mem_word(Imem_Addr);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic push_stream(input logic [31:0] start, input int n);
        logic [31:0] p;
        exp_t        e;
        p = start;
        for (int i = 0; i < n; i++) begin
            e.instr = mem_word(p[11:2]);
            e.pc    = p;
            sb.push_back(e);
            p = p + 32'd4;
        end
    endtask

    task automatic sample();
        exp_t e;
        @(negedge Clk);
        if (Imem_Req) req_cnt++;
        if (Instr_Valid && Instr_Ready) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_pop", Instr_PC, 32'hDEAD_BEEF);
            end else begin
                e = sb.pop_front();
                check_eq("instr", Instr, e.instr);
                check_eq("instr_pc", Instr_PC, e.pc);
            end
        end
    endtask

    task automatic adv();
        @(posedge Clk);
        #1;
    endtask

    task automatic tick();
        sample();
        adv();
    endtask

    task automatic do_redirect(input logic [1:0] mode, input logic [31:0] base,
                               input logic [31:0] imm, input logic [31:0] tgt);
        Redir_Valid = 1'b1;
        Redir_Mode  = mode;
        Redir_Base  = base;
        Redir_Immed = imm;
        sample();
        check_eq("redir_req", 32'(Imem_Req), 32'd0);
        check_eq("redir_head_valid", 32'(Instr_Valid), 32'd1);
        sb.delete();
        push_stream(tgt, 32);
        adv();
        Redir_Valid = 1'b0;
        Redir_Mode  = REDIR_NONE;
        sample();
        check_eq("tgt_req", 32'(Imem_Req), 32'd1);
        check_eq("tgt_addr", 32'(Imem_Addr), 32'({22'd0, tgt[11:2]}));
        check_eq("gap1_valid", 32'(Instr_Valid), 32'd0);
        adv();
        sample();
        check_eq("gap2_valid", 32'(Instr_Valid), 32'd0);
        adv();
        sample();
        check_eq("tgt_valid", 32'(Instr_Valid), 32'd1);
        check_eq("tgt_pc", Instr_PC, tgt);
        adv();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge Clk);
        #1;
        sample();
        check_eq("rst_req", 32'(Imem_Req), 32'd0);
        check_eq("rst_valid", 32'(Instr_Valid), 32'd0);
        check_eq("rst_instr", Instr, 32'd0);
        check_eq("rst_pc", Instr_PC, 32'd0);
        adv();

        // Reset release: fetch-to-decode latency of two cycles.
        Reset_n     = 1'b1;
        Instr_Ready = 1'b1;
        push_stream(32'h0, 64);
        sample();
        check_eq("c0_req", 32'(Imem_Req), 32'd1);
        check_eq("c0_addr", 32'(Imem_Addr), 32'd0);
        check_eq("c0_valid", 32'(Instr_Valid), 32'd0);
        adv();
        sample();
        check_eq("c1_valid", 32'(Instr_Valid), 32'd0);
        adv();
        sample();
        check_eq("c2_valid", 32'(Instr_Valid), 32'd1);
        adv();
        repeat (6) tick();

        // Mid-stream reset clears outputs at once.
        Reset_n = 1'b0;
        sample();
        check_eq("arst_valid", 32'(Instr_Valid), 32'd0);
        check_eq("arst_req", 32'(Imem_Req), 32'd0);
        check_eq("arst_pc", Instr_PC, 32'd0);
        sb.delete();
        Instr_Ready = 1'b0;
        adv();

        // Back-pressure: four credits then stall.
        Reset_n = 1'b1;
        push_stream(32'h0, 64);
        req_cnt = 0;
        repeat (10) tick();
        check_eq("stall_req_cnt", 32'(req_cnt), 32'd4);
        sample();
        check_eq("stall_req", 32'(Imem_Req), 32'd0);
        check_eq("stall_valid", 32'(Instr_Valid), 32'd1);
        adv();
        Instr_Ready = 1'b1;
        sample();
        check_eq("resume_req0", 32'(Imem_Req), 32'd0);
        adv();
        sample();
        check_eq("resume_req1", 32'(Imem_Req), 32'd1);
        check_eq("resume_addr", 32'(Imem_Addr), 32'd4);
        adv();
        repeat (6) tick();

        do_redirect(REDIR_REL, 32'h20, 32'h10, 32'h34);
        repeat (3) tick();
        do_redirect(REDIR_ABS, 32'h0, 32'h103, 32'h100);
        repeat (3) tick();

        // Reserved and none modes must leave the stream untouched.
        Redir_Valid = 1'b1;
        Redir_Mode  = REDIR_RSVD;
        Redir_Base  = 32'h40;
        Redir_Immed = 32'h800;
        sample();
        check_eq("rsvd_req", 32'(Imem_Req), 32'd1);
        adv();
        Redir_Mode = REDIR_NONE;
        sample();
        check_eq("none_req", 32'(Imem_Req), 32'd1);
        adv();
        Redir_Valid = 1'b0;
        repeat (4) tick();

        // Redirect with a full queue: head accepted, rest dropped.
        Instr_Ready = 1'b0;
        repeat (8) tick();
        Instr_Ready = 1'b1;
        do_redirect(REDIR_ABS, 32'h0, 32'h200, 32'h200);
        repeat (3) tick();

        do_redirect(REDIR_ABS, 32'h0, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
        repeat (4) tick();

        // Second async reset restarts fetch at RESET_PC.
        Reset_n = 1'b0;
        sample();
        check_eq("arst2_valid", 32'(Instr_Valid), 32'd0);
        sb.delete();
        adv();
        Reset_n = 1'b1;
        push_stream(32'h0, 16);
        sample();
        check_eq("restart_req", 32'(Imem_Req), 32'd1);
        check_eq("restart_addr", 32'(Imem_Addr), 32'd0);
        adv();
        sample();
        check_eq("restart_gap", 32'(Instr_Valid), 32'd0);
        adv();
        sample();
        check_eq("restart_valid", 32'(Instr_Valid), 32'd1);
        adv();
        repeat (4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
